// File: rtl/regbank_lanes.sv
// Lane-masked register bank: two combinational read ports, one write port
// with write-through bypass, and a post-reset clear sweep.
module regbank_lanes #(
  parameter int DATA_W         = 32,
  parameter int LANE_W         = 16,
  parameter int ADDR_W         = 4,
  parameter int ZERO_REG       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          addr_a,
  input  logic [ADDR_W-1:0]          addr_b,
  output logic [DATA_W-1:0]          data_a,
  output logic [DATA_W-1:0]          data_b,
  input  logic [ADDR_W-1:0]          addr_d,
  input  logic [DATA_W-1:0]          data_d,
  input  logic                       we,
  input  logic [DATA_W/LANE_W-1:0]   lane_mask,
  input  logic                       rep,
  output logic                       busy,
  output logic                       clear_done
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] wmask;
  logic              wen;
  logic              zero_wr;

  always_comb begin
    wdata = '0;
    wmask = '0;
    for (int i = 0; i < LANES; i++) begin
      wdata[i*LANE_W +: LANE_W] = rep ? data_d[LANE_W-1:0]
                                      : data_d[i*LANE_W +: LANE_W];
      wmask[i*LANE_W +: LANE_W] = {LANE_W{lane_mask[i]}};
    end
  end

  always_comb begin
    busy       = reset ? (state_q == S_CLEAR) : (CLEAR_ON_RESET != 0);
    clear_done = reset && (state_q == S_CLEAR) && (&cnt_q);
    zero_wr    = (ZERO_REG != 0) && (addr_d == '0);
    wen        = we && !busy && (|lane_mask) && !zero_wr;
  end

  // Read path: busy and the hardwired zero register mask the array,
  // a write to the same address forwards only its selected lanes.
  function automatic logic [DATA_W-1:0] rd(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = regs_q[a];
    if (wen && (a == addr_d))
      v = (v & ~wmask) | (wdata & wmask);
    if (busy || ((ZERO_REG != 0) && (a == '0)))
      v = '0;
    return v;
  endfunction

  always_comb begin
    data_a = rd(addr_a);
    data_b = rd(addr_b);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    if (reset && (state_q == S_CLEAR)) begin
      regs_d[cnt_q] = '0;
      cnt_d         = cnt_q + 1'b1;
      if (&cnt_q)
        state_d = S_IDLE;
    end
    if (wen)
      regs_d[addr_d] = (regs_q[addr_d] & ~wmask) | (wdata & wmask);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    regs_q <= regs_d;
  end

endmodule

// File: tb/tb_regbank_lanes.sv
// Bench for regbank_lanes: directed table, sweep/reset sequences and a
// randomized run against a lane-level behavioural model.
module tb_regbank_lanes;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int AW = 4;
  localparam int LN = DW / LW;
  localparam int NR = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [AW-1:0] addr_b = '0;
  logic [AW-1:0] addr_d = '0;
  logic [DW-1:0] data_d = '0;
  logic          we = 1'b0;
  logic          rep = 1'b0;
  logic [LN-1:0] lane_mask = '0;

  logic [DW-1:0] da1, db1, da0, db0;
  logic          busy1, done1, busy0, done0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regbank_lanes dut (
    .clk(clk), .reset(reset),
    .addr_a(addr_a), .addr_b(addr_b),
    .data_a(da1), .data_b(db1),
    .addr_d(addr_d), .data_d(data_d),
    .we(we), .lane_mask(lane_mask), .rep(rep),
    .busy(busy1), .clear_done(done1)
  );

  regbank_lanes #(.ZERO_REG(0)) dut0 (
    .clk(clk), .reset(reset),
    .addr_a(addr_a), .addr_b(addr_b),
    .data_a(da0), .data_b(db0),
    .addr_d(addr_d), .data_d(data_d),
    .we(we), .lane_mask(lane_mask), .rep(rep),
    .busy(busy0), .clear_done(done0)
  );

  // Model: index 0 mirrors dut (zero reg), index 1 mirrors dut0.
  logic [DW-1:0] mreg [2][NR];
  int            sweep_left = NR;

  function automatic logic m_busy();
    return !reset || (sweep_left > 0);
  endfunction

  function automatic logic m_done();
    return reset && (sweep_left == 1);
  endfunction

  function automatic logic m_wen(input int k);
    return we && !m_busy() && (lane_mask != '0)
           && !(k == 0 && addr_d == '0);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < LN; i++)
      if (lane_mask[i])
        r[i*LW +: LW] = rep ? data_d[LW-1:0] : data_d[i*LW +: LW];
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int k,
                                           input logic [AW-1:0] a);
    if (m_busy()) return '0;
    if (k == 0 && a == '0) return '0;
    if (m_wen(k) && a == addr_d) return merge(mreg[k][a]);
    return mreg[k][a];
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      sweep_left <= NR;
    end else if (sweep_left > 0) begin
      for (int k = 0; k < 2; k++)
        mreg[k][NR-sweep_left] <= '0;
      sweep_left <= sweep_left - 1;
    end
    for (int k = 0; k < 2; k++)
      if (m_wen(k))
        mreg[k][addr_d] <= merge(mreg[k][addr_d]);
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " busy"}, {31'd0, busy1}, {31'd0, m_busy()});
    chk({tag, " busy0"}, {31'd0, busy0}, {31'd0, m_busy()});
    chk({tag, " done"}, {31'd0, done1}, {31'd0, m_done()});
    chk({tag, " done0"}, {31'd0, done0}, {31'd0, m_done()});
    chk({tag, " a"}, da1, exp_rd(0, addr_a));
    chk({tag, " b"}, db1, exp_rd(0, addr_b));
    chk({tag, " a0"}, da0, exp_rd(1, addr_a));
    chk({tag, " b0"}, db0, exp_rd(1, addr_b));
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] ad;
    logic [LN-1:0] m;
    logic          rep;
    logic [DW-1:0] dd;
    logic [AW-1:0] aa;
    logic [AW-1:0] ab;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [DW-1:0] ea0;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 4'd5, 2'b11, 1'b0, 32'hDEADBEEF, 4'd5, 4'd0,
               32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 4'd5, 2'b11, 1'b0, 32'h0, 4'd5, 4'd5,
               32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 4'd5, 2'b10, 1'b1, 32'h00001234, 4'd5, 4'd5,
               32'h1234BEEF, 32'h1234BEEF, 32'h1234BEEF};
    tbl[3] = '{1'b0, 4'd5, 2'b00, 1'b0, 32'h0, 4'd5, 4'd5,
               32'h1234BEEF, 32'h1234BEEF, 32'h1234BEEF};
    tbl[4] = '{1'b1, 4'd0, 2'b11, 1'b0, 32'hFFFFFFFF, 4'd0, 4'd5,
               32'h0, 32'h1234BEEF, 32'hFFFFFFFF};
    tbl[5] = '{1'b0, 4'd0, 2'b00, 1'b0, 32'h0, 4'd0, 4'd5,
               32'h0, 32'h1234BEEF, 32'hFFFFFFFF};
    tbl[6] = '{1'b1, 4'd7, 2'b01, 1'b1, 32'h0000ABCD, 4'd7, 4'd7,
               32'h0000ABCD, 32'h0000ABCD, 32'h0000ABCD};
    tbl[7] = '{1'b1, 4'd7, 2'b00, 1'b0, 32'hFFFFFFFF, 4'd7, 4'd7,
               32'h0000ABCD, 32'h0000ABCD, 32'h0000ABCD};
    tbl[8] = '{1'b1, 4'd7, 2'b10, 1'b0, 32'h5555AAAA, 4'd7, 4'd7,
               32'h5555ABCD, 32'h5555ABCD, 32'h5555ABCD};
    tbl[9] = '{1'b0, 4'd7, 2'b00, 1'b0, 32'h0, 4'd7, 4'd5,
               32'h5555ABCD, 32'h1234BEEF, 32'h5555ABCD};

    // Reset held for three edges.
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst busy", {31'd0, busy1}, 32'd1);
      chk("rst done", {31'd0, done1}, 32'd0);
      chk("rst data_a", da1, 32'h0);
      tick();
    end
    reset = 1'b1;

    // Sweep with a write attempt on cycle 3.
    for (int c = 1; c <= 17; c++) begin
      if (c == 3) begin
        we = 1'b1; addr_d = 4'd10;
        data_d = 32'h11111111; lane_mask = 2'b11;
      end
      @(negedge clk);
      chk($sformatf("sweep%0d busy", c), {31'd0, busy1},
          (c <= 16) ? 32'd1 : 32'd0);
      chk($sformatf("sweep%0d done", c), {31'd0, done1},
          (c == 16) ? 32'd1 : 32'd0);
      check_model($sformatf("sweep%0d", c));
      tick();
      we = 1'b0;
    end

    for (int a = 0; a < NR; a++) begin
      addr_a = AW'(a);
      addr_b = AW'(NR - 1 - a);
      @(negedge clk);
      chk($sformatf("clr a%0d", a), da1, 32'h0);
      chk($sformatf("clr b%0d", a), db1, 32'h0);
      chk($sformatf("clr0 a%0d", a), da0, 32'h0);
      tick();
    end

    for (int i = 0; i < 10; i++) begin
      we = tbl[i].we; addr_d = tbl[i].ad; lane_mask = tbl[i].m;
      rep = tbl[i].rep; data_d = tbl[i].dd;
      addr_a = tbl[i].aa; addr_b = tbl[i].ab;
      @(negedge clk);
      chk($sformatf("vec%0d a", i), da1, tbl[i].ea);
      chk($sformatf("vec%0d b", i), db1, tbl[i].eb);
      chk($sformatf("vec%0d a0", i), da0, tbl[i].ea0);
      check_model($sformatf("vec%0d", i));
      tick();
    end
    we = 1'b0; rep = 1'b0; lane_mask = '0;

    // Reset again, then a one-cycle reset at sweep cycle 8.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk($sformatf("pre%0d done", c), {31'd0, done1}, 32'd0);
      check_model($sformatf("pre%0d", c));
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("midrst busy", {31'd0, busy1}, 32'd1);
    chk("midrst done", {31'd0, done1}, 32'd0);
    tick();
    reset = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      chk($sformatf("resweep%0d busy", c), {31'd0, busy1},
          (c <= 16) ? 32'd1 : 32'd0);
      chk($sformatf("resweep%0d done", c), {31'd0, done1},
          (c == 16) ? 32'd1 : 32'd0);
      check_model($sformatf("resweep%0d", c));
      tick();
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 99) != 0);
      we        = ($urandom_range(0, 3) != 0);
      addr_d    = AW'($urandom_range(0, NR - 1));
      data_d    = DW'($urandom);
      lane_mask = LN'($urandom_range(0, 3));
      rep       = 1'($urandom_range(0, 1));
      addr_a    = ($urandom_range(0, 2) == 0) ? addr_d
                                              : AW'($urandom_range(0, NR - 1));
      addr_b    = ($urandom_range(0, 2) == 0) ? addr_d
                                              : AW'($urandom_range(0, NR - 1));
      @(negedge clk);
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regbank_lanes.md
Name: regbank_lanes

Overview:
- Parametrised next-generation CPU register bank: N-bit registers, 2^ADDR_W entries, two combinational read ports, one lane-masked write port.
- Generalises the full/high-half write to an arbitrary per-lane write mask, with an optional lane-0 replicate mode.
- Adds a hardware clear sweep after reset, so registers need no initial blocks and are zeroed on every reset.
- Sits in the CPU decode/writeback stages: read ports feed the ALU, the write port is driven by writeback.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of LANE_W.
- LANE_W, 16, write-lane width; LANES = DATA_W/LANE_W.
- ADDR_W, 4, register address width; NREGS = 2^ADDR_W.
- ZERO_REG, 1, if 1 register 0 always reads 0 and ignores writes.
- CLEAR_ON_RESET, 1, if 1 all registers are zeroed by a sweep after reset release.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- addr_a  in  ADDR_W  read port A address
- addr_b  in  ADDR_W  read port B address
- data_a  out  DATA_W  read port A data (combinational)
- data_b  out  DATA_W  read port B data (combinational)
- addr_d  in  ADDR_W  write address
- data_d  in  DATA_W  write data
- we  in  1  write enable
- lane_mask  in  LANES  per-lane write select; bit i covers bits [i*LANE_W +: LANE_W]
- rep  in  1  1: every selected lane takes data_d[LANE_W-1:0]; 0: lane i takes data_d lane i
- busy  out  1  clear sweep in progress; reads return 0, writes dropped
- clear_done  out  1  one-cycle pulse on the last sweep cycle

Behaviour:
- One clock, reset is synchronous and active-low; all state updates on posedge clk.
- While reset=0:
  - sweep counter <= 0; state <= CLEAR if CLEAR_ON_RESET else IDLE.
  - busy = CLEAR_ON_RESET; clear_done = 0.
  - data_a/data_b = 0 when CLEAR_ON_RESET=1.
- State CLEAR:
  - Each cycle, reg[cnt] <= 0, then cnt <= cnt+1.
  - When cnt == NREGS-1: clear_done=1 for that cycle, next state IDLE, busy falls the following cycle.
  - With reset released at edge E, the sweep takes exactly NREGS cycles.
  - Reset asserted mid-sweep restarts from cnt=0.
- State IDLE: busy=0; CLEAR is never re-entered except via reset.
- Effective write (wen) = we & ~busy & |lane_mask & ~(ZERO_REG & addr_d==0).
- On wen, for each lane i with lane_mask[i]=1:
  - reg[addr_d] lane i <= rep ? data_d[LANE_W-1:0] : data_d lane i.
  - Unselected lanes hold.
- Writes with we=1 during busy are silently dropped.
- Reads, per port (A shown; B identical):
  - busy=1 -> 0.
  - ZERO_REG & addr_a==0 -> 0.
  - addr_a==addr_d & wen -> same-cycle bypass: selected lanes show the value being written, unselected lanes show the stored value.
  - Otherwise -> reg[addr_a].
- Both ports may read the same address; bypass applies to each independently.
- With ZERO_REG=0, register 0 is an ordinary register.
- No read latency; write is visible on the registered path the cycle after the edge and via bypass during the write cycle.

Test Plan:
- Reset sweep (defaults): hold reset=0 for 3 cycles, release -> busy=1 for 16 cycles, clear_done pulses on cycle 16, busy=0 on cycle 17; every address then reads 0x00000000.
- Full write/bypass: we=1, addr_d=5, mask=2'b11, rep=0, data_d=0xDEADBEEF, addr_a=5 -> data_a=0xDEADBEEF in the same cycle; next cycle with we=0, data_a=0xDEADBEEF.
- High-lane replicate: reg5=0xDEADBEEF; we=1, addr_d=5, mask=2'b10, rep=1, data_d=0x00001234 -> data_b(addr_b=5)=0x1234BEEF in the same cycle and after the edge.
- Zero register: we=1, addr_d=0, data_d=0xFFFFFFFF -> data_a(addr 0)=0, both during and after the write; with ZERO_REG=0 -> reads 0xFFFFFFFF.
- Write during sweep: at sweep cycle 3, we=1, addr_d=10, data_d=0x11111111 -> dropped; reg10 reads 0 after busy falls.
- Mid-sweep reset: drop reset at sweep cycle 8 for 1 cycle -> sweep restarts, clear_done occurs 16 cycles after the new release; no early pulse.
